bf2_bundle_pipe: RTL and testbench

//  Parametrised radix-2 DIF butterfly bundle (BF2I stage) for the FFT datapath: DEPTH complex lanes per beat,

---
 rtl/bf2_pkg.sv | 11 +
 rtl/bf2_bundle_pipe_if.sv | 26 ++
 rtl/bf2_pair.sv | 12 +
 rtl/bf2_bundle_pipe.sv | 90 +++++++++
 tb/tb_bf2_bundle_pipe.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bf2_pkg.sv
// bf2_pkg: shared mode type and arithmetic helpers for the BF2I butterfly bundle.
package bf2_pkg;
    typedef enum logic [1:0] {BF2_GROW, BF2_HALF, BF2_BYPASS, BF2_RSVD} bf2_mode_e;
    function automatic int bf2_ngroup(input int depth, input int offset);
        return depth / (2 * offset);
    endfunction
    // Round half up, then halve; callers widen first so the +1 cannot overflow.
    function automatic logic signed [31:0] bf2_scale(input logic signed [31:0] x);
        return (x + 32'sd1) >>> 1;
    endfunction
endpackage

// File: rtl/bf2_bundle_pipe_if.sv
// bf2_bundle_pipe_if: input/output beat streams of the butterfly bundle with valid/ready handshakes.
interface bf2_bundle_pipe_if #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
);
    import bf2_pkg::*;
    logic                    in_valid;
    logic                    in_ready;
    bf2_mode_e               in_mode;
    logic                    in_last;
    logic signed [WIDTH-1:0] din_R [DEPTH];
    logic signed [WIDTH-1:0] din_Q [DEPTH];
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic signed [WIDTH:0]   dout_R [DEPTH];
    logic signed [WIDTH:0]   dout_Q [DEPTH];
    modport slave (
        input  in_valid, in_mode, in_last, din_R, din_Q, out_ready,
        output in_ready, out_valid, out_last, dout_R, dout_Q
    );
    modport master (
        output in_valid, in_mode, in_last, din_R, din_Q, out_ready,
        input  in_ready, out_valid, out_last, dout_R, dout_Q
    );
endinterface

// File: rtl/bf2_pair.sv
// bf2_pair: one radix-2 butterfly, sum and difference at one bit of growth so it never wraps.
module bf2_pair #(
    parameter int WIDTH = 9
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH:0]   s,
    output logic signed [WIDTH:0]   d
);
    assign s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
endmodule

// File: rtl/bf2_bundle_pipe.sv
// bf2_bundle_pipe: DEPTH-lane BF2I butterfly bundle with a 2-stage stallable valid/ready pipeline.
module bf2_bundle_pipe
    import bf2_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int OFFSET = 4
) (
    input logic              clk,
    input logic              rst,
    input logic              en,
    bf2_bundle_pipe_if.slave bus
);
    localparam int W1 = WIDTH + 1;
    localparam int NG = bf2_ngroup(DEPTH, OFFSET);
    if (OFFSET < 1 || (OFFSET & (OFFSET - 1)) != 0 || DEPTH % (2 * OFFSET) != 0) begin : g_bad_cfg
        $error("bf2_bundle_pipe: DEPTH must be a multiple of 2*OFFSET and OFFSET a power of two");
    end
    logic                 va, vb, adv_a, adv_b, byp, a_last, b_last;
    bf2_mode_e            a_mode;
    logic signed [W1-1:0] na_R [DEPTH];
    logic signed [W1-1:0] na_Q [DEPTH];
    logic signed [W1-1:0] a_R  [DEPTH];
    logic signed [W1-1:0] a_Q  [DEPTH];
    logic signed [W1-1:0] nb_R [DEPTH];
    logic signed [W1-1:0] nb_Q [DEPTH];
    logic signed [W1-1:0] b_R  [DEPTH];
    logic signed [W1-1:0] b_Q  [DEPTH];
    assign adv_b        = en && (!vb || bus.out_ready);
    assign adv_a        = en && (!va || adv_b);
    assign bus.in_ready = adv_a;
    assign byp          = bus.in_mode == BF2_BYPASS;
    for (genvar g = 0; g < NG; g++) begin : grp
        for (genvar i = 0; i < OFFSET; i++) begin : lane
            localparam int A = 2 * g * OFFSET + i;
            localparam int B = A + OFFSET;
            logic signed [W1-1:0] s_r, d_r, s_q, d_q;
            bf2_pair #(.WIDTH(WIDTH)) u_r (.a(bus.din_R[A]), .b(bus.din_R[B]), .s(s_r), .d(d_r));
            bf2_pair #(.WIDTH(WIDTH)) u_q (.a(bus.din_Q[A]), .b(bus.din_Q[B]), .s(s_q), .d(d_q));
            assign na_R[A] = byp ? W1'(bus.din_R[A]) : s_r;
            assign na_R[B] = byp ? W1'(bus.din_R[B]) : d_r;
            assign na_Q[A] = byp ? W1'(bus.din_Q[A]) : s_q;
            assign na_Q[B] = byp ? W1'(bus.din_Q[B]) : d_q;
        end
    end
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            nb_R[k] = (a_mode == BF2_HALF) ? W1'(bf2_scale(32'(a_R[k]))) : a_R[k];
            nb_Q[k] = (a_mode == BF2_HALF) ? W1'(bf2_scale(32'(a_Q[k]))) : a_Q[k];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            va     <= 1'b0;
            vb     <= 1'b0;
            a_mode <= BF2_GROW;
            a_last <= 1'b0;
            b_last <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                a_R[k] <= '0;
                a_Q[k] <= '0;
                b_R[k] <= '0;
                b_Q[k] <= '0;
            end
        end else begin
            if (adv_a) begin
                va <= bus.in_valid;
                if (bus.in_valid) begin
                    a_mode <= bus.in_mode;
                    a_last <= bus.in_last;
                    a_R    <= na_R;
                    a_Q    <= na_Q;
                end
            end
            // A bubble clears the tag so out_last never lingers on an idle output.
            if (adv_b) begin
                vb     <= va;
                b_last <= va && a_last;
                if (va) begin
                    b_R <= nb_R;
                    b_Q <= nb_Q;
                end
            end
        end
    end
    assign bus.out_valid = vb;
    assign bus.out_last  = b_last;
    assign bus.dout_R    = b_R;
    assign bus.dout_Q    = b_Q;
endmodule

// File: tb/tb_bf2_bundle_pipe.sv
// tb_bf2_bundle_pipe: directed checks of reset, GROW/HALF/BYPASS arithmetic, backpressure, enable and reset recovery.
module tb_bf2_bundle_pipe;
    import bf2_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_g [8] = '{510, -512, -1, -1, 0, 0, 511, -511};
    int   exp_h [8] = '{255, -256, 2, -1, 0, 0, 2, -1};
    bf2_bundle_pipe_if #(.WIDTH(9), .DEPTH(16)) bus ();
    bf2_bundle_pipe #(.WIDTH(9), .DEPTH(16), .OFFSET(4)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask
    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask
    task automatic clr();
        bus.in_valid = 1'b0;
        bus.in_mode  = BF2_GROW;
        bus.in_last  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.din_R[k] = '0;
            bus.din_Q[k] = '0;
        end
    endtask
    initial begin
        int   sent, rcv, prev_r0;
        logic stall_prev, prev_last;
        clr();
        bus.out_ready = 1'b1;
        // reset held with a valid beat offered
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 16; k++) bus.din_R[k] = 9'(k + 1);
        tick();
        tick();
        chkb("rst_vld", bus.out_valid, 1'b0);
        chkb("rst_last", bus.out_last, 1'b0);
        chk("rst_r0", int'(bus.dout_R[0]), 0);
        chk("rst_q15", int'(bus.dout_Q[15]), 0);
        rst = 1'b0;
        clr();
        tick();
        #1;
        chkb("rst_rel_vld", bus.out_valid, 1'b0);
        // GROW streaming, one beat per cycle
        for (int c = 0; c < 10; c++) begin
            clr();
            if (c < 8) begin
                bus.in_valid = 1'b1;
                bus.in_last  = (c == 7);
                for (int k = 0; k < 16; k++) begin
                    bus.din_R[k] = 9'(2 * (k + 1) + c);
                    bus.din_Q[k] = 9'(3 * (k + 1));
                end
            end
            #1;
            chkb("g_rdy", bus.in_ready, 1'b1);
            chkb("g_vld", bus.out_valid, c >= 2);
            if (c >= 2) begin
                chk("g_r0", int'(bus.dout_R[0]), 12 + 2 * (c - 2));
                chk("g_r4", int'(bus.dout_R[4]), -8);
                chk("g_r11", int'(bus.dout_R[11]), 56 + 2 * (c - 2));
                chk("g_r15", int'(bus.dout_R[15]), -8);
                chk("g_q0", int'(bus.dout_Q[0]), 18);
                chk("g_q4", int'(bus.dout_Q[4]), -12);
                chkb("g_last", bus.out_last, c == 9);
            end
            tick();
        end
        // GROW edge values
        clr();
        bus.in_valid = 1'b1;
        bus.din_R[0] = 9'(255);  bus.din_R[4] = 9'(255);
        bus.din_R[1] = 9'(-256); bus.din_R[5] = 9'(-256);
        bus.din_R[2] = 9'(255);  bus.din_R[6] = 9'(-256);
        bus.din_R[3] = 9'(-256); bus.din_R[7] = 9'(255);
        tick();
        clr();
        tick();
        #1;
        chkb("e_vld", bus.out_valid, 1'b1);
        for (int k = 0; k < 8; k++) chk($sformatf("e_r%0d", k), int'(bus.dout_R[k]), exp_g[k]);
        chk("e_q0", int'(bus.dout_Q[0]), 0);
        // HALF beat followed by BYPASS beat
        clr();
        bus.in_valid = 1'b1;
        bus.in_mode  = BF2_HALF;
        bus.din_R[0] = 9'(255);  bus.din_R[4] = 9'(255);
        bus.din_R[1] = 9'(-256); bus.din_R[5] = 9'(-256);
        bus.din_R[2] = 9'(3);
        bus.din_R[3] = 9'(-3);
        bus.din_Q[2] = 9'(3);
        tick();
        clr();
        bus.in_valid = 1'b1;
        bus.in_mode  = BF2_BYPASS;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.din_R[k] = 9'(k * 30 - 256);
            bus.din_Q[k] = 9'(255 - k * 31);
        end
        tick();
        clr();
        #1;
        chkb("h_vld", bus.out_valid, 1'b1);
        chkb("h_last", bus.out_last, 1'b0);
        for (int k = 0; k < 8; k++) chk($sformatf("h_r%0d", k), int'(bus.dout_R[k]), exp_h[k]);
        chk("h_q2", int'(bus.dout_Q[2]), 2);
        chk("h_q6", int'(bus.dout_Q[6]), 2);
        tick();
        #1;
        chkb("b_vld", bus.out_valid, 1'b1);
        chkb("b_last", bus.out_last, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b_r%0d", k), int'(bus.dout_R[k]), k * 30 - 256);
            chk($sformatf("b_q%0d", k), int'(bus.dout_Q[k]), 255 - k * 31);
        end
        tick();
        // backpressure: out_ready low for cycles 3..7
        sent = 0;
        rcv = 0;
        prev_r0 = 0;
        stall_prev = 1'b0;
        prev_last = 1'b0;
        for (int c = 0; c < 30; c++) begin
            clr();
            bus.out_ready = !(c >= 3 && c < 8);
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = (sent % 2 == 1) ? BF2_BYPASS : BF2_GROW;
                bus.in_last  = (sent == 7);
                bus.din_R[0] = 9'(sent);
                bus.din_R[4] = 9'(1);
            end
            #1;
            if (stall_prev) begin
                chkb("bp_hold_v", bus.out_valid, 1'b1);
                chk("bp_hold_r0", int'(bus.dout_R[0]), prev_r0);
                chkb("bp_hold_l", bus.out_last, prev_last);
            end
            if (c == 7) chkb("bp_rdy_low", bus.in_ready, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_r0", int'(bus.dout_R[0]), (rcv % 2 == 1) ? rcv : rcv + 1);
                chk("bp_r4", int'(bus.dout_R[4]), (rcv % 2 == 1) ? 1 : rcv - 1);
                chkb("bp_last", bus.out_last, rcv == 7);
                rcv++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_r0 = int'(bus.dout_R[0]);
            prev_last = bus.out_last;
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        chk("bp_sent", sent, 8);
        chk("bp_count", rcv, 8);
        // en=0 holds a pending output even with out_ready=1
        clr();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.din_R[0] = 9'(5);
        bus.din_R[4] = 9'(2);
        tick();
        clr();
        tick();
        en = 1'b0;
        #1;
        chkb("en_pre_v", bus.out_valid, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chkb("en_v", bus.out_valid, 1'b1);
            chk("en_r0", int'(bus.dout_R[0]), 7);
            chk("en_r4", int'(bus.dout_R[4]), 3);
            chkb("en_rdy", bus.in_ready, 1'b0);
        end
        en = 1'b1;
        tick();
        #1;
        chkb("en_drain", bus.out_valid, 1'b0);
        // reset mid-frame discards in-flight beats
        clr();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.din_R[0] = 9'(100);
        tick();
        bus.din_R[0] = 9'(101);
        tick();
        #1;
        chkb("rm_pre_v", bus.out_valid, 1'b1);
        rst = 1'b1;
        clr();
        tick();
        #1;
        chkb("rm_v", bus.out_valid, 1'b0);
        chkb("rm_last", bus.out_last, 1'b0);
        chk("rm_r0", int'(bus.dout_R[0]), 0);
        rst = 1'b0;
        tick();
        #1;
        chkb("rm_v2", bus.out_valid, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.din_R[0] = 9'(9);
        bus.din_R[4] = 9'(3);
        tick();
        clr();
        tick();
        #1;
        chkb("nf_v", bus.out_valid, 1'b1);
        chk("nf_r0", int'(bus.dout_R[0]), 12);
        chk("nf_r4", int'(bus.dout_R[4]), 6);
        chkb("nf_last", bus.out_last, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
